optimized_shadow_pwm: RTL and testbench

//  Single-channel, fixed-period, duty-cycle PWM generator with a double-buffered duty register.
//  - The CPU writes a duty value N into a shadow register at any time.
//  - The active register copies the shadow only at a frame boundary, so each PWM frame is glitch-free.
//  - The block sits between a CPU-side register write strobe and a board-level PWM pin.

---
 rtl/pwm_pkg.sv | 7 +
 rtl/pwm_frame_counter.sv | 33 +++
 rtl/optimized_shadow_pwm.sv | 54 +++++
 tb/tb_optimized_shadow_pwm.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared width, duty type and counter limit for the shadow-buffered PWM.
// Imported by the frame counter and the optimized_shadow_pwm top.
package pwm_pkg;
    localparam int PWM_W = 8;
    typedef logic [PWM_W-1:0] duty_t;
    localparam duty_t CNT_MAX = '1;
endpackage

// File: rtl/pwm_frame_counter.sv
// Free-running frame counter: wraps every 2**W clocks, held at zero while disabled.
// Exposes the next count and the frame-boundary flag used for the active reload.
module pwm_frame_counter
    import pwm_pkg::*;
#(
    parameter int W = PWM_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    output logic [W-1:0] o_cnt_next,
    output logic         o_frame_end
);
    localparam logic [W-1:0] ONE  = 1;
    localparam logic [W-1:0] LAST = '1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] w_cnt_next;

    always_comb begin
        w_cnt_next = '0;
        if (i_en) w_cnt_next = cnt_q + ONE;
    end

    // Disabled counts as a boundary so the active duty keeps tracking the shadow.
    assign o_frame_end = !i_en || (cnt_q == LAST);
    assign o_cnt_next  = w_cnt_next;

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= w_cnt_next;
    end
endmodule

// File: rtl/optimized_shadow_pwm.sv
// Double-buffered duty PWM: shadow written by the CPU, active reloaded per frame.
// Optional frame_start pulse when PWM_FRAME_STROBE_EN is defined.
module optimized_shadow_pwm
    import pwm_pkg::*;
#(
    parameter int W = PWM_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] cpu_data_in,
    input  logic         cpu_update,
    output logic         pwm_out
`ifdef PWM_FRAME_STROBE_EN
    ,
    output logic         frame_start
`endif
);
    logic [W-1:0] n_shadow_q;
    logic [W-1:0] n_active_q;
    logic [W-1:0] w_active_next;
    logic [W-1:0] w_cnt_next;
    logic         w_frame_end;

    pwm_frame_counter #(.W(W)) u_cnt (
        .clk         (clk),
        .rst         (rst),
        .i_en        (en),
        .o_cnt_next  (w_cnt_next),
        .o_frame_end (w_frame_end)
    );

    // Reload uses the registered shadow; a same-cycle write waits a frame.
    assign w_active_next = w_frame_end ? n_shadow_q : n_active_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            n_shadow_q <= '0;
            n_active_q <= '0;
            pwm_out    <= 1'b0;
        end else begin
            if (cpu_update) n_shadow_q <= cpu_data_in;
            n_active_q <= w_active_next;
            pwm_out    <= en && (w_cnt_next < w_active_next);
        end
    end

`ifdef PWM_FRAME_STROBE_EN
    always_ff @(posedge clk) begin
        if (rst) frame_start <= 1'b0;
        else     frame_start <= en && (w_cnt_next == '0);
    end
`endif
endmodule

// File: tb/tb_optimized_shadow_pwm.sv
// Directed self-checking bench for optimized_shadow_pwm (W=8, 256-clk frames).
// Build with +define+PWM_FRAME_STROBE_EN to also check the frame strobe.
module tb_optimized_shadow_pwm;
    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] cpu_data_in;
    logic       cpu_update;
    logic       pwm_out;
`ifdef PWM_FRAME_STROBE_EN
    logic       frame_start;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    optimized_shadow_pwm dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .cpu_data_in (cpu_data_in),
        .cpu_update  (cpu_update),
        .pwm_out     (pwm_out)
`ifdef PWM_FRAME_STROBE_EN
        ,
        .frame_start (frame_start)
`endif
    );

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_duty(input logic [7:0] d);
        cpu_data_in = d;
        cpu_update  = 1'b1;
        tick();
        cpu_update  = 1'b0;
    endtask

    // Advance until the counter shows its last value; bounded.
    task automatic sync_to_last;
        int n;
        n = 0;
        while (dut.u_cnt.cnt_q != 8'd255 && n < 300) begin
            tick();
            n++;
        end
        total++;
        if (dut.u_cnt.cnt_q != 8'd255) begin
            bad++;
            $display("FAIL sync_timeout cnt=%0d want=255", dut.u_cnt.cnt_q);
        end
    endtask

    // Observe one whole frame, counter values 0..255.
    task automatic measure(output int highs, output int fl,
                           output int fs_cnt, output int fs_idx);
        highs  = 0;
        fl     = 256;
        fs_cnt = 0;
        fs_idx = -1;
        for (int i = 0; i < 256; i++) begin
            tick();
            if (pwm_out === 1'b1) highs++;
            else if (fl == 256) fl = i;
`ifdef PWM_FRAME_STROBE_EN
            if (frame_start === 1'b1) begin
                fs_cnt++;
                fs_idx = i;
            end
`endif
        end
    endtask

    task automatic check_frame(input string nm, input int n);
        int h, fl, fc, fi;
        measure(h, fl, fc, fi);
        total++;
        if (h != n) begin
            bad++;
            $display("FAIL %s_highs got=%0d want=%0d", nm, h, n);
        end
        total++;
        if (fl != n) begin
            bad++;
            $display("FAIL %s_first_low got=%0d want=%0d", nm, fl, n);
        end
`ifdef PWM_FRAME_STROBE_EN
        total++;
        if (fc != 1 || fi != 0) begin
            bad++;
            $display("FAIL %s_frame_start count=%0d idx=%0d want=1/0", nm, fc, fi);
        end
`endif
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b0; cpu_data_in = 8'd0; cpu_update = 1'b0;
        tick(2);
        total++;
        if (pwm_out !== 1'b0) begin
            bad++; $display("FAIL reset_pwm got=%b want=0", pwm_out);
        end
        total++;
        if (dut.n_shadow_q !== 8'd0) begin
            bad++; $display("FAIL reset_shadow got=%0d want=0", dut.n_shadow_q);
        end
        total++;
        if (dut.n_active_q !== 8'd0) begin
            bad++; $display("FAIL reset_active got=%0d want=0", dut.n_active_q);
        end
`ifdef PWM_FRAME_STROBE_EN
        total++;
        if (frame_start !== 1'b0) begin
            bad++; $display("FAIL reset_fs got=%b want=0", frame_start);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_basic_duty;
        write_duty(8'd20);
        total++;
        if (dut.n_shadow_q !== 8'd20) begin
            bad++; $display("FAIL basic_shadow got=%0d want=20", dut.n_shadow_q);
        end
        tick();
        total++;
        if (dut.n_active_q !== 8'd20) begin
            bad++; $display("FAIL basic_idle_track got=%0d want=20", dut.n_active_q);
        end
        en = 1'b1;
        tick();
        total++;
        if (pwm_out !== 1'b1 || dut.u_cnt.cnt_q !== 8'd1) begin
            bad++;
            $display("FAIL basic_first_high pwm=%b cnt=%0d want=1/1",
                     pwm_out, dut.u_cnt.cnt_q);
        end
        sync_to_last();
        check_frame("basic_f1", 20);
        check_frame("basic_f2", 20);
    endtask

    task automatic test_mid_frame_update;
        int h, fl, fc, fi;
        h = 0; fl = 256;
        for (int i = 0; i < 256; i++) begin
            tick();
            if (pwm_out === 1'b1) h++;
            else if (fl == 256) fl = i;
            if (i == 10) begin
                cpu_data_in = 8'd5;
                cpu_update  = 1'b1;
            end
            if (i == 11) cpu_update = 1'b0;
            if (i == 12) begin
                total++;
                if (dut.n_shadow_q !== 8'd5 || dut.n_active_q !== 8'd20) begin
                    bad++;
                    $display("FAIL mid_regs shadow=%0d active=%0d want=5/20",
                             dut.n_shadow_q, dut.n_active_q);
                end
            end
        end
        total++;
        if (h != 20 || fl != 20) begin
            bad++; $display("FAIL mid_cur_frame highs=%0d fl=%0d want=20/20", h, fl);
        end
        measure(h, fl, fc, fi);
        total++;
        if (h != 5 || fl != 5) begin
            bad++; $display("FAIL mid_next_frame highs=%0d fl=%0d want=5/5", h, fl);
        end
        total++;
        if (dut.n_active_q !== 8'd5) begin
            bad++; $display("FAIL mid_active got=%0d want=5", dut.n_active_q);
        end
    endtask

    task automatic test_held_strobe;
        tick(50);
        cpu_data_in = 8'd20; cpu_update = 1'b1;
        tick();
        total++;
        if (dut.n_shadow_q !== 8'd20 || dut.n_active_q !== 8'd5) begin
            bad++;
            $display("FAIL held_1 shadow=%0d active=%0d want=20/5",
                     dut.n_shadow_q, dut.n_active_q);
        end
        cpu_data_in = 8'd5;
        tick();
        total++;
        if (dut.n_shadow_q !== 8'd5) begin
            bad++; $display("FAIL held_2 shadow=%0d want=5", dut.n_shadow_q);
        end
        cpu_data_in = 8'd20;
        tick();
        cpu_update = 1'b0;
        total++;
        if (dut.n_shadow_q !== 8'd20 || dut.n_active_q !== 8'd5) begin
            bad++;
            $display("FAIL held_3 shadow=%0d active=%0d want=20/5",
                     dut.n_shadow_q, dut.n_active_q);
        end
        sync_to_last();
        tick();
        total++;
        if (dut.n_active_q !== 8'd20) begin
            bad++; $display("FAIL held_wrap active=%0d want=20", dut.n_active_q);
        end
    endtask

    task automatic test_extremes;
        write_duty(8'd0);
        sync_to_last();
        check_frame("ext_zero", 0);
        write_duty(8'd255);
        total++;
        if (dut.n_active_q !== 8'd0) begin
            bad++; $display("FAIL ext_no_forward active=%0d want=0", dut.n_active_q);
        end
        sync_to_last();
        check_frame("ext_max", 255);
    endtask

    task automatic test_en_toggle;
        tick(30);
        write_duty(8'd40);
        en = 1'b0;
        tick();
        total++;
        if (pwm_out !== 1'b0 || dut.u_cnt.cnt_q !== 8'd0) begin
            bad++;
            $display("FAIL toggle_off pwm=%b cnt=%0d want=0/0",
                     pwm_out, dut.u_cnt.cnt_q);
        end
        total++;
        if (dut.n_active_q !== 8'd40) begin
            bad++; $display("FAIL toggle_track active=%0d want=40", dut.n_active_q);
        end
        en = 1'b1;
        tick();
        total++;
        if (pwm_out !== 1'b1 || dut.u_cnt.cnt_q !== 8'd1) begin
            bad++;
            $display("FAIL toggle_on pwm=%b cnt=%0d want=1/1",
                     pwm_out, dut.u_cnt.cnt_q);
        end
        sync_to_last();
        check_frame("toggle_frame", 40);
    endtask

    task automatic test_reset_mid_frame;
        tick(10);
        rst = 1'b1;
        tick();
        total++;
        if (pwm_out !== 1'b0 || dut.u_cnt.cnt_q !== 8'd0) begin
            bad++;
            $display("FAIL rstmid_out pwm=%b cnt=%0d want=0/0",
                     pwm_out, dut.u_cnt.cnt_q);
        end
        total++;
        if (dut.n_shadow_q !== 8'd0 || dut.n_active_q !== 8'd0) begin
            bad++;
            $display("FAIL rstmid_regs shadow=%0d active=%0d want=0/0",
                     dut.n_shadow_q, dut.n_active_q);
        end
        rst = 1'b0;
        en  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_duty();
        test_mid_frame_update();
        test_held_strobe();
        test_extremes();
        test_en_toggle();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
